// File: rtl/pipe_pkg.sv
// Shared widths and helpers for the pipeline stage register and its counters.
package pipe_pkg;

   localparam int CW_W_DEF  = 35;
   localparam int IMM_W_DEF = 32;
   localparam int PC_W_DEF  = 32;
   localparam int CNT_W_DEF = 16;

   localparam logic [CW_W_DEF-1:0] NOP_CW = '0;

   // Number of live beats (output register plus skid) thrown away by a flush.
   function automatic logic [1:0] beatCount(input logic outValid, input logic skValid);
      return {1'b0, outValid} + {1'b0, skValid};
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: adds 0..3 per enabled cycle and sticks at all-ones.
module pipe_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic [1:0]   amount,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;
   logic [W:0]   w_sum;

   // One extra bit catches the overflow that triggers saturation.
   assign w_sum = {1'b0, r_count} + {{(W-1){1'b0}}, amount};

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (inc)
         r_count <= w_sum[W] ? '1 : w_sum[W-1:0];
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_stage.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// bubble and stall/drop counters. Define PIPE_SKID_EN for a one-entry skid buffer.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CW_W  = CW_W_DEF,
   parameter int IMM_W = IMM_W_DEF,
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             bubble,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW_W-1:0]  cw_in,
   input  logic [IMM_W-1:0] imm_in,
   input  logic [PC_W-1:0]  pc_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW_W-1:0]  cw_out,
   output logic [IMM_W-1:0] imm_out,
   output logic [PC_W-1:0]  pc_out,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   logic             r_outValid;
   logic [CW_W-1:0]  r_cw;
   logic [IMM_W-1:0] r_imm;
   logic [PC_W-1:0]  r_pc;

   logic w_load;
   logic w_inXfer;
   logic w_skValid;

   assign w_load = !r_outValid | out_ready;

`ifdef PIPE_SKID_EN
   logic             r_skValid;
   logic [CW_W-1:0]  r_skCw;
   logic [IMM_W-1:0] r_skImm;
   logic [PC_W-1:0]  r_skPc;

   // Ready comes only from registered skid state, cutting the out_ready path.
   assign in_ready  = !flush & !bubble & !r_skValid;
   assign w_skValid = r_skValid;

   always_ff @(posedge clk) begin
      if (rst | flush) begin
         r_skValid <= 1'b0;
         r_skCw    <= '0;
         r_skImm   <= '0;
         r_skPc    <= '0;
      end else if (w_load) begin
         r_skValid <= 1'b0;
      end else if (w_inXfer) begin
         r_skValid <= 1'b1;
         r_skCw    <= cw_in;
         r_skImm   <= imm_in;
         r_skPc    <= pc_in;
      end
   end
`else
   assign in_ready  = !flush & !bubble & w_load;
   assign w_skValid = 1'b0;
`endif

   assign w_inXfer = in_valid & in_ready;

   // Empty output slots always carry the all-zero NOP payload.
   always_ff @(posedge clk) begin
      if (rst | flush) begin
         r_outValid <= 1'b0;
         r_cw       <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
      end else if (w_load) begin
`ifdef PIPE_SKID_EN
         if (r_skValid) begin
            r_outValid <= 1'b1;
            r_cw       <= r_skCw;
            r_imm      <= r_skImm;
            r_pc       <= r_skPc;
         end else
`endif
         if (w_inXfer) begin
            r_outValid <= 1'b1;
            r_cw       <= cw_in;
            r_imm      <= imm_in;
            r_pc       <= pc_in;
         end else begin
            r_outValid <= 1'b0;
            r_cw       <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
         end
      end
   end

   assign out_valid = r_outValid;
   assign cw_out    = r_cw;
   assign imm_out   = r_imm;
   assign pc_out    = r_pc;

   pipe_sat_counter #(.W(CNT_W)) u_stallCnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (r_outValid & !out_ready & !flush),
      .amount (2'd1),
      .count  (stall_cnt)
   );

   pipe_sat_counter #(.W(CNT_W)) u_dropCnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (flush),
      .amount (beatCount(r_outValid, w_skValid)),
      .count  (drop_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_pipe_stage_reg;

   localparam int CW_W  = 35;
   localparam int IMM_W = 32;
   localparam int PC_W  = 32;

`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, flush, bubble, in_valid, out_ready;
   logic [CW_W-1:0]  cw_in;
   logic [IMM_W-1:0] imm_in;
   logic [PC_W-1:0]  pc_in;

   logic             in_ready, out_valid;
   logic [CW_W-1:0]  cw_out;
   logic [IMM_W-1:0] imm_out;
   logic [PC_W-1:0]  pc_out;
   logic [15:0]      stall_cnt, drop_cnt;

   logic             s_inReady, s_outValid;
   logic [CW_W-1:0]  s_cwOut;
   logic [IMM_W-1:0] s_immOut;
   logic [PC_W-1:0]  s_pcOut;
   logic [1:0]       s_stallCnt, s_dropCnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
      .in_valid(in_valid), .in_ready(in_ready),
      .cw_in(cw_in), .imm_in(imm_in), .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .cw_out(cw_out), .imm_out(imm_out), .pc_out(pc_out),
      .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
   );

   pipe_stage_reg #(.CNT_W(2)) dutSat (
      .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
      .in_valid(in_valid), .in_ready(s_inReady),
      .cw_in(cw_in), .imm_in(imm_in), .pc_in(pc_in),
      .out_valid(s_outValid), .out_ready(out_ready),
      .cw_out(s_cwOut), .imm_out(s_immOut), .pc_out(s_pcOut),
      .stall_cnt(s_stallCnt), .drop_cnt(s_dropCnt)
   );

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cw_in = '0; imm_in = '0; pc_in = '0;
      step();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (cw_out !== '0) begin errors++; $display("[TB] FAIL reset_cw got %h exp 0", cw_out); end
      checks++; if (pc_out !== '0) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0", pc_out); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall got %0d exp 0", stall_cnt); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop got %0d exp 0", drop_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_streaming();
      logic [PC_W-1:0] pcs [3];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_in  = pcs[i];
         cw_in  = 35'h10 + 35'(i);
         imm_in = 32'hA000 + 32'(i);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
         checks++; if (pc_out !== pcs[i]) begin errors++; $display("[TB] FAIL stream_pc[%0d] got %h exp %h", i, pc_out, pcs[i]); end
         checks++; if (imm_out !== 32'hA000 + 32'(i)) begin errors++; $display("[TB] FAIL stream_imm[%0d] got %h exp %h", i, imm_out, 32'hA000 + 32'(i)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain_valid got %b exp 0", out_valid); end
      checks++; if (pc_out !== '0) begin errors++; $display("[TB] FAIL stream_drain_pc got %h exp 0", pc_out); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stream_stall got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      cw_in = 35'h1; imm_in = 32'h0; pc_in = 32'h300;
      step();
      cw_in = 35'h2; pc_in = 32'h304;
      #1;
      checks++; if (in_ready !== SKID) begin errors++; $display("[TB] FAIL bp_ready_first got %b exp %b", in_ready, SKID); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (cw_out !== 35'h1) begin errors++; $display("[TB] FAIL bp_cw[%0d] got %h exp 1", i, cw_out); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
      end
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL bp_stall got %0d exp 3", stall_cnt); end
   endtask

   task automatic test_flush();
      logic [15:0] expDrop;
      expDrop = SKID ? 16'd2 : 16'd1;
      flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %b exp 0", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b exp 0", out_valid); end
      checks++; if (cw_out !== '0) begin errors++; $display("[TB] FAIL flush_cw got %h exp 0", cw_out); end
      checks++; if (pc_out !== '0) begin errors++; $display("[TB] FAIL flush_pc got %h exp 0", pc_out); end
      checks++; if (drop_cnt !== expDrop) begin errors++; $display("[TB] FAIL flush_drop got %0d exp %0d", drop_cnt, expDrop); end
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL flush_stall got %0d exp 3", stall_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_after got %b exp 1", in_ready); end
   endtask

   task automatic test_bubble();
      out_ready = 1'b1; in_valid = 1'b1;
      cw_in = 35'h5; imm_in = 32'h7; pc_in = 32'h200;
      bubble = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bubble_ready got %b exp 0", in_ready); end
      step();
      bubble = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid got %b exp 0", out_valid); end
      checks++; if (cw_out !== '0) begin errors++; $display("[TB] FAIL bubble_cw got %h exp 0", cw_out); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bubble_next_valid got %b exp 1", out_valid); end
      checks++; if (pc_out !== 32'h200) begin errors++; $display("[TB] FAIL bubble_next_pc got %h exp 200", pc_out); end
      checks++; if (cw_out !== 35'h5) begin errors++; $display("[TB] FAIL bubble_next_cw got %h exp 5", cw_out); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bubble_drain_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_saturation();
      logic [1:0] expSat;
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0; pc_in = 32'h400; cw_in = 35'h9;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         expSat = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
         checks++; if (s_stallCnt !== expSat) begin errors++; $display("[TB] FAIL sat_stall[%0d] got %0d exp %0d", i, s_stallCnt, expSat); end
      end
      checks++; if (stall_cnt !== 16'd6) begin errors++; $display("[TB] FAIL sat_wide_stall got %0d exp 6", stall_cnt); end
      checks++; if (pc_out !== 32'h400) begin errors++; $display("[TB] FAIL sat_hold_pc got %h exp 400", pc_out); end
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1; pc_in = 32'h500; cw_in = 35'hB; imm_in = 32'h3;
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %b exp 0", out_valid); end
      checks++; if (cw_out !== '0) begin errors++; $display("[TB] FAIL mid_cw got %h exp 0", cw_out); end
      checks++; if (imm_out !== '0) begin errors++; $display("[TB] FAIL mid_imm got %h exp 0", imm_out); end
      checks++; if (pc_out !== '0) begin errors++; $display("[TB] FAIL mid_pc got %h exp 0", pc_out); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_stall got %0d exp 0", stall_cnt); end
      checks++; if (s_stallCnt !== 2'd0) begin errors++; $display("[TB] FAIL mid_sat_stall got %0d exp 0", s_stallCnt); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_drop got %0d exp 0", drop_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b exp 1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle_valid got %b exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_bubble();
      test_saturation();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-width IF/ID latch. It carries control word, immediate and PC between any two pipeline stages and adds a valid/ready handshake, downstream back-pressure, flush and bubble insertion. It also keeps saturating stall and flush-drop counters. One instance sits between each pair of adjacent stages (IF/ID, ID/EX, EX/MEM, ...).

## Interface
- CW_W, 35, control word width
- IMM_W, 32, immediate width
- PC_W, 32, PC width
- CNT_W, 16, width of each performance counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held beats and any offered beat this cycle
- bubble  in  1  refuse upstream beat this cycle, insert empty slot
- in_valid  in  1  upstream beat offered
- in_ready  out  1  stage accepts beat (transfer when in_valid & in_ready)
- cw_in / imm_in / pc_in  in  CW_W / IMM_W / PC_W  upstream payload
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream consumes beat (transfer when out_valid & out_ready)
- cw_out / imm_out / pc_out  out  CW_W / IMM_W / PC_W  registered payload
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
- drop_cnt  out  CNT_W  valid beats discarded by flush

## Operation
- Reset: out_valid=0, all payload outputs 0, stall_cnt=0, drop_cnt=0, skid empty.
- Priority per cycle: rst > flush > load/hold.
- Payload invariant: whenever out_valid=0, cw_out/imm_out/pc_out are all-zero, i.e. the NOP control word.
- `load = !valid_q | out_ready`. When load is false the output register holds, regardless of bubble.
- On load:
  - A skid beat, if present, moves to the output register.
  - Otherwise, if in_valid & in_ready, the input beat is captured with out_valid=1.
  - Otherwise out_valid=0 and the payload is zeroed.
- Bubble:
  - Forces in_ready=0.
  - Does not block a skid-to-output move.
  - Never destroys a held beat.
- Flush:
  - Forces in_ready=0.
  - Next cycle out_valid=0, payload zeroed, skid emptied.
  - drop_cnt += number of valid beats discarded (0, 1 or 2).
- in_ready without skid: `!flush & !bubble & load`. This is a combinational path from out_ready.
- Counters:
  - stall_cnt increments each cycle with out_valid & !out_ready & !flush.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - A flush and a stall cycle in the same cycle: drop_cnt updates, stall_cnt does not.

## Timing
- Latency is 1 cycle from an input transfer to out_valid, when the stage is empty or out_ready=1.
- Full throughput: one beat per cycle while out_ready=1 and flush=bubble=0.
- Flush asserted in cycle N: out_valid=0 in cycle N+1. An upstream beat offered in N is not accepted.
- Bubble asserted in cycle N with load true: out_valid=0 in N+1. The upstream beat is still offered in N+1.
- Reset in mid-stream: all state is cleared next cycle. No transfer is counted.

## Configuration
- `PIPE_SKID_EN` defined:
  - One-entry skid buffer.
  - in_ready = `!flush & !bubble & !skid_valid`, with skid_valid registered. This breaks the out_ready→in_ready combinational path.
  - A beat accepted while the output is held (out_valid & !out_ready) goes to skid.
  - in_ready drops the following cycle.
  - Skid drains on the next load.
- `PIPE_SKID_EN` undefined:
  - No skid storage.
  - in_ready as in Operation, combinational from out_ready.
  - drop_cnt increments by at most 1 per flush.

## Structure
- Shared package pipe_pkg:
  - default widths CW_W_DEF=35, IMM_W_DEF=32, PC_W_DEF=32.
  - NOP_CW = all-zero control word constant.
  - counter width default.
- Sub-module pipe_sat_counter: parameter W; ports clk, rst, inc, amount[1:0], count. Saturating add. Instantiated twice.

## Test plan
- Streaming: out_ready=1, beats pc_in=0x100,0x104,0x108 on consecutive cycles → appear on pc_out one cycle later, back-to-back; stall_cnt=0.
- Back-pressure: out_ready=0 for 3 cycles with cw_out=0x1 held → cw_out stable, stall_cnt=3. Without skid, in_ready=0. With PIPE_SKID_EN, one further beat accepted, then in_ready=0.
- Flush with PIPE_SKID_EN, output and skid both valid → next cycle out_valid=0, payload 0, drop_cnt=2. Without skid → drop_cnt=1.
- Bubble: out_ready=1, in_valid=1, pc_in=0x200, bubble for 1 cycle → next cycle out_valid=0, cw_out=0. The following cycle pc_out=0x200, no beat lost.
- Saturation: CNT_W=2, hold out_ready=0 for 6 cycles → stall_cnt reaches 3 and stays 3.
- Reset mid-stream: rst during back-pressure → next cycle out_valid=0, all outputs and counters 0, in_ready reasserts.
